// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy (pending-producer) scoreboard.
// Two combinational read ports, one write port, one reserve port; register 0 is hardwired zero.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] ReserveRegister,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  Stall
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regFile [Depth];
    logic [Depth-1:0]      busyQ;
    logic [Depth-1:0]      busyD;

    logic writeEn;
    logic reserveEn;
    logic writeReserved;
    logic bypassEn;

    assign writeEn       = RegWrite && (WriteRegister != '0);
    assign reserveEn     = Reserve && (ReserveRegister != '0);
    assign writeReserved = reserveEn && (ReserveRegister == WriteRegister);
    assign bypassEn      = (BYPASS != 0) && writeEn;

    // Reserve is applied after the write clear so a same-cycle reissue keeps the entry busy.
    always_comb begin
        busyD = busyQ;
        if (writeEn) begin
            busyD[WriteRegister] = 1'b0;
        end
        if (reserveEn) begin
            busyD[ReserveRegister] = 1'b1;
        end
        busyD[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regFile[i] <= '0;
            end
            busyQ <= '0;
        end else begin
            if (writeEn) begin
                regFile[WriteRegister] <= WriteData;
            end
            busyQ <= busyD;
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        Busy1     = 1'b0;
        Busy2     = 1'b0;

        if (ReadRegister1 != '0) begin
            ReadData1 = regFile[ReadRegister1];
            Busy1     = busyQ[ReadRegister1];
            if (bypassEn && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
                if (!writeReserved) begin
                    Busy1 = 1'b0;
                end
            end
        end

        if (ReadRegister2 != '0) begin
            ReadData2 = regFile[ReadRegister2];
            Busy2     = busyQ[ReadRegister2];
            if (bypassEn && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
                if (!writeReserved) begin
                    Busy2 = 1'b0;
                end
            end
        end

        Stall = Busy1 | Busy2;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing and one non-bypassing instance
// share stimulus; expected values are hand-computed constants.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        Reserve;
    logic [4:0]  ReserveRegister;

    logic [31:0] rdB1, rdB2, rdN1, rdN2;
    logic        busyB1, busyB2, busyN1, busyN2, stallB, stallN;

    int passCnt = 0;
    int totalCnt = 0;

    regfile_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1)) dutB (
        .clk(clk), .rst_n(rst_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rdB1), .ReadData2(rdB2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .Reserve(Reserve), .ReserveRegister(ReserveRegister),
        .Busy1(busyB1), .Busy2(busyB2), .Stall(stallB)
    );

    regfile_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0)) dutN (
        .clk(clk), .rst_n(rst_n),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rdN1), .ReadData2(rdN2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .Reserve(Reserve), .ReserveRegister(ReserveRegister),
        .Busy1(busyN1), .Busy2(busyN2), .Stall(stallN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Commit the current inputs on the next rising edge, then return write/reserve to idle.
    task automatic nextCycle;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        Reserve  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        Reserve = 1'b0;
        ReserveRegister = '0;

        nextCycle();
        nextCycle();
        rst_n = 1'b1;

        // Reset state
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd13;
        #1;
        chk("reset_rd1", rdB1, 32'h0);
        chk("reset_rd2", rdB2, 32'h0);
        chk("reset_stall", {31'b0, stallB}, 32'h0);

        // Write 7, read it on both ports next cycle
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hA5A5A5A5;
        nextCycle();
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        #1;
        chk("wr7_rd1", rdB1, 32'hA5A5A5A5);
        chk("wr7_rd2", rdB2, 32'hA5A5A5A5);
        chk("wr7_nobyp_rd1", rdN1, 32'hA5A5A5A5);
        chk("wr7_stall", {31'b0, stallB}, 32'h0);

        // Register 0 ignores writes and reserves
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFFFFFF;
        Reserve = 1'b1; ReserveRegister = 5'd0;
        #1;
        chk("r0_samecyc_rd1", rdB1, 32'h0);
        chk("r0_samecyc_busy1", {31'b0, busyB1}, 32'h0);
        nextCycle();
        #1;
        chk("r0_rd1", rdB1, 32'h0);
        chk("r0_rd2_nobyp", rdN2, 32'h0);
        chk("r0_busy2", {31'b0, busyB2}, 32'h0);

        // Same-cycle forwarding vs. none
        ReadRegister2 = 5'd5;
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h12345678;
        #1;
        chk("byp_rd2", rdB2, 32'h12345678);
        chk("nobyp_rd2_old", rdN2, 32'h0);
        nextCycle();
        #1;
        chk("nobyp_rd2_new", rdN2, 32'h12345678);

        // Reserve 3, then write it back
        Reserve = 1'b1; ReserveRegister = 5'd3;
        nextCycle();
        ReadRegister1 = 5'd3;
        #1;
        chk("res3_busy1", {31'b0, busyB1}, 32'h1);
        chk("res3_stall", {31'b0, stallB}, 32'h1);
        chk("res3_stall_nobyp", {31'b0, stallN}, 32'h1);
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h1;
        #1;
        chk("wb3_byp_busy1", {31'b0, busyB1}, 32'h0);
        chk("wb3_nobyp_busy1", {31'b0, busyN1}, 32'h1);
        nextCycle();
        #1;
        chk("wb3_busy1", {31'b0, busyB1}, 32'h0);
        chk("wb3_stall", {31'b0, stallB}, 32'h0);
        chk("wb3_rd1", rdB1, 32'h1);
        chk("wb3_rd1_nobyp", rdN1, 32'h1);

        // Reserve and write 9 together: data lands, busy stays set
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h0000DEAD;
        Reserve = 1'b1; ReserveRegister = 5'd9;
        #1;
        chk("r9_samecyc_byp_rd1", rdB1, 32'h0000DEAD);
        nextCycle();
        #1;
        chk("r9_rd1", rdB1, 32'h0000DEAD);
        chk("r9_rd2", rdB2, 32'h0000DEAD);
        chk("r9_busy1", {31'b0, busyB1}, 32'h1);
        chk("r9_busy2_nobyp", {31'b0, busyN2}, 32'h1);

        // Write 4, reserve 6, then reset mid-sequence
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'h0000BEEF;
        Reserve = 1'b1; ReserveRegister = 5'd6;
        nextCycle();
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
        #1;
        chk("pre_rst_rd1", rdB1, 32'h0000BEEF);
        chk("pre_rst_busy2", {31'b0, busyB2}, 32'h1);
        rst_n = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'h00001234;
        Reserve = 1'b1; ReserveRegister = 5'd8;
        nextCycle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rd1", rdB1, 32'h0);
        chk("post_rst_busy2", {31'b0, busyB2}, 32'h0);
        chk("post_rst_stall", {31'b0, stallB}, 32'h0);
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd8;
        #1;
        chk("post_rst_rd9", rdB1, 32'h0);
        chk("post_rst_busy9", {31'b0, busyB1}, 32'h0);
        chk("post_rst_busy8", {31'b0, busyB2}, 32'h0);

        // First edge after reset resumes normal operation
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'h00000055;
        Reserve = 1'b1; ReserveRegister = 5'd11;
        nextCycle();
        ReadRegister1 = 5'd10; ReadRegister2 = 5'd11;
        #1;
        chk("resume_rd1", rdB1, 32'h00000055);
        chk("resume_busy2", {31'b0, busyB2}, 32'h1);
        chk("resume_stall", {31'b0, stallB}, 32'h1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
